// File: rtl/instr_fetch.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, word-addressed
// instruction memory with a program-load port, and the IF/ID register feeding decode.
module instr_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   if_id_instr,
    output logic [31:0]                   if_id_pc_plus4,
    output logic                          if_id_valid,
    output logic [31:0]                   fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0]   imem [IMEM_DEPTH];

    logic [31:0]   pc_p0;
    logic [31:0]   instr_p1;
    logic [31:0]   pc_plus4_p1;
    logic          vld_p1;
    logic [31:0]   count_p1;

    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_next;

    // PC bits above the memory span are ignored, so fetches wrap around the memory.
    assign fetch_idx  = pc_p0[AW+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_next    = pc_p0 + 32'd4;

    // Program load; the fetch read above sees the old word on a same-cycle write.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Stage p0 -> p1: PC update and IF/ID capture (reset > branch > stall > fetch)
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            instr_p1    <= 32'd0;
            pc_plus4_p1 <= 32'd0;
            vld_p1      <= 1'b0;
            count_p1    <= 32'd0;
        end else if (branch_taken) begin
            pc_p0       <= branch_target & ~32'd3;
            instr_p1    <= 32'd0;
            pc_plus4_p1 <= 32'd0;
            vld_p1      <= 1'b0;
        end else if (!stall) begin
            pc_p0       <= pc_next;
            instr_p1    <= fetch_word;
            pc_plus4_p1 <= pc_next;
            vld_p1      <= 1'b1;
            count_p1    <= count_p1 + 32'd1;
        end
    end

    assign pc             = pc_p0;
    assign if_id_instr    = instr_p1;
    assign if_id_pc_plus4 = pc_plus4_p1;
    assign if_id_valid    = vld_p1;
    assign fetch_count    = count_p1;

endmodule
